// File: rtl/sync_pkg.sv
// Shared constants and helpers for the level synchronizer family.
package sync_pkg;

    localparam int SYNC_MIN_FLOP_NUM = 2;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic bit params_ok(input int flop_num, input int filt_cycles);
        return (flop_num >= SYNC_MIN_FLOP_NUM) && (filt_cycles >= 1);
    endfunction

endpackage

// File: rtl/sync_filt_chan.sv
// Single-bit stability filter: dout follows din only after FILT_CYCLES
// consecutive mismatching samples; shorter excursions are discarded.
module sync_filt_chan
    import sync_pkg::*;
#(
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int              CNT_W    = clog2(FILT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic             state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_BIT;
            cnt   <= '0;
        end else if (din == state) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            state <= din;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign dout = state;

endmodule

// File: rtl/sync_level_edge_filt.sv
// Multi-bit level synchronizer with per-bit reset value, registered rise/fall
// pulses and an optional glitch filter (macro SYNC_LEVEL_EDGE_FILT_FILTER_EN).
module sync_level_edge_filt
    import sync_pkg::*;
#(
    parameter int                      SIGNAL_WIDTH = 1,
    parameter int                      FLOP_NUM     = 3,
    parameter logic [SIGNAL_WIDTH-1:0] RST_VAL      = {SIGNAL_WIDTH{1'b0}},
    parameter int                      FILT_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIGNAL_WIDTH-1:0] sync_in,
    output logic [SIGNAL_WIDTH-1:0] sync_out,
    output logic [SIGNAL_WIDTH-1:0] rise_pulse,
    output logic [SIGNAL_WIDTH-1:0] fall_pulse,
    output logic                    chg_any
);

    if (!params_ok(FLOP_NUM, FILT_CYCLES) || SIGNAL_WIDTH < 1) begin : g_param_err
        $error("sync_level_edge_filt: illegal SIGNAL_WIDTH/FLOP_NUM/FILT_CYCLES");
    end

    logic [SIGNAL_WIDTH-1:0] ff [FLOP_NUM];
    logic [SIGNAL_WIDTH-1:0] ff_last;
    logic [SIGNAL_WIDTH-1:0] hist;

    // NOTE: the chain is reset to RST_VAL (not left unreset like a memory) so
    // that sync_out and hist agree at release and no spurious pulse fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLOP_NUM; i++) begin
                ff[i] <= RST_VAL;
            end
        end else begin
            ff[0] <= sync_in;
            for (int i = 1; i < FLOP_NUM; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign ff_last = ff[FLOP_NUM-1];

`ifdef SYNC_LEVEL_EDGE_FILT_FILTER_EN
    for (genvar b = 0; b < SIGNAL_WIDTH; b++) begin : g_filt
        sync_filt_chan #(
            .FILT_CYCLES (FILT_CYCLES),
            .RST_BIT     (RST_VAL[b])
        ) u_filt (
            .clk  (clk),
            .rst  (rst),
            .din  (ff_last[b]),
            .dout (sync_out[b])
        );
    end
`else
    assign sync_out = ff_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= RST_VAL;
        end else begin
            hist <= sync_out;
        end
    end

    // Pulses line up with the first cycle sync_out shows its new value.
    assign rise_pulse = sync_out & ~hist;
    assign fall_pulse = ~sync_out & hist;
    assign chg_any    = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_level_edge_filt.sv
// Scoreboard bench for sync_level_edge_filt; adapts to the filter macro.
module tb_sync_level_edge_filt;

    localparam int W  = 4;
    localparam int FC = 4;
    localparam logic [W-1:0] RV = 4'b1010;
`ifdef SYNC_LEVEL_EDGE_FILT_FILTER_EN
    localparam int FN      = 2;
    localparam bit FILT_ON = 1'b1;
`else
    localparam int FN      = 3;
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int LAT = FILT_ON ? FN + FC : FN;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] sync_in;
    logic [W-1:0] sync_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         chg_any;

    sync_level_edge_filt #(
        .SIGNAL_WIDTH (W),
        .FLOP_NUM     (FN),
        .RST_VAL      (RV),
        .FILT_CYCLES  (FC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sync_out   (sync_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .chg_any    (chg_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    exp_t         sb[$];
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_s;
    logic [W-1:0] m_hist;
    int           m_run[W];

    int           step_idx;
    int           rise0_n;
    int           last_rise0;
    int           chg_n;
    int           last_chg;
    logic [W-1:0] chg_rise;
    logic [W-1:0] chg_fall;

    function automatic void model_reset();
        m_pipe.delete();
        for (int i = 0; i < FN; i++) m_pipe.push_back(RV);
        m_s    = RV;
        m_hist = RV;
        for (int b = 0; b < W; b++) m_run[b] = 0;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.out  = RV;
        e.rise = '0;
        e.fall = '0;
        e.chg  = 1'b0;
        return e;
    endfunction

    // Behavioural view: delayed input via a FIFO of samples, then a
    // mismatch-run-length filter, then edge compare with the previous output.
    function automatic exp_t model_edge(input logic [W-1:0] din);
        exp_t         e;
        logic [W-1:0] seen;
        logic [W-1:0] prev_out;
        logic [W-1:0] new_out;
        seen     = m_pipe[0];
        prev_out = FILT_ON ? m_s : seen;
        for (int b = 0; b < W; b++) begin
            if (seen[b] == m_s[b]) begin
                m_run[b] = 0;
            end else begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] >= FC) begin
                    m_s[b]   = seen[b];
                    m_run[b] = 0;
                end
            end
        end
        m_pipe.push_back(din);
        void'(m_pipe.pop_front());
        m_hist  = prev_out;
        new_out = FILT_ON ? m_s : m_pipe[0];
        e.out   = new_out;
        e.rise  = new_out & ~m_hist;
        e.fall  = ~new_out & m_hist;
        e.chg   = |(e.rise | e.fall);
        return e;
    endfunction

    task automatic clear_obs();
        step_idx   = 0;
        rise0_n    = 0;
        last_rise0 = 0;
        chg_n      = 0;
        last_chg   = 0;
        chg_rise   = '0;
        chg_fall   = '0;
    endtask

    // One clock: drive at negedge, push the expectation, compare #1 after posedge.
    task automatic step(input logic [W-1:0] din, input logic r, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        sync_in = din;
        rst     = r;
        if (r) begin
            model_reset();
            sb.push_back(reset_exp());
        end else begin
            sb.push_back(model_edge(din));
        end
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {sync_out, rise_pulse, fall_pulse, chg_any};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s step %0d: out=%b rise=%b fall=%b chg=%b, expected out=%b rise=%b fall=%b chg=%b",
                     tag, step_idx + 1, got.out, got.rise, got.fall, got.chg,
                     e.out, e.rise, e.fall, e.chg);
        end
        step_idx++;
        if (rise_pulse[0]) begin
            rise0_n++;
            last_rise0 = step_idx;
        end
        if (chg_any) begin
            chg_n++;
            last_chg = step_idx;
            chg_rise = rise_pulse;
            chg_fall = fall_pulse;
        end
    endtask

    task automatic settle(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0, "settle");
    endtask

    task automatic test_reset();
        int hit;
        rst     = 1'b1;
        sync_in = 4'b0101;
        model_reset();
        #1;
        checks++;
        if ({sync_out, rise_pulse, fall_pulse, chg_any} !== {RV, 4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_t0: out=%b rise=%b fall=%b chg=%b, expected out=%b and no pulses",
                     sync_out, rise_pulse, fall_pulse, chg_any, RV);
        end
        for (int i = 0; i < 3; i++) step(4'b0101, 1'b1, "reset_hold");
        clear_obs();
        hit = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0101, 1'b0, "reset_release");
            if (hit == 0 && sync_out === 4'b0101) hit = step_idx;
        end
        checks++;
        if (hit != LAT) begin
            errors++;
            $display("FAIL reset_release_latency: got edge %0d, expected %0d", hit, LAT);
        end
        checks++;
        if (chg_n != 1 || chg_rise !== 4'b0101 || chg_fall !== 4'b1010) begin
            errors++;
            $display("FAIL reset_release_pulses: chg cycles=%0d rise=%b fall=%b, expected 1 cycle rise=0101 fall=1010",
                     chg_n, chg_rise, chg_fall);
        end
    endtask

    task automatic test_latency();
        settle(4'b0000, 14);
        clear_obs();
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0, "latency");
        checks++;
        if (rise0_n != 1 || last_rise0 != LAT) begin
            errors++;
            $display("FAIL latency: rises=%0d at edge %0d, expected 1 at edge %0d", rise0_n, last_rise0, LAT);
        end
    endtask

    task automatic test_glitch();
        settle(4'b0000, 14);
        clear_obs();
        for (int i = 0; i < 3; i++)  step(4'b0001, 1'b0, "glitch3");
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, "glitch3");
        checks++;
        if (rise0_n != (FILT_ON ? 0 : 1)) begin
            errors++;
            $display("FAIL glitch3_rises: got %0d, expected %0d", rise0_n, FILT_ON ? 0 : 1);
        end
        clear_obs();
        for (int i = 0; i < 4; i++)  step(4'b0001, 1'b0, "pulse4");
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, "pulse4");
        checks++;
        if (rise0_n != 1 || last_rise0 != LAT) begin
            errors++;
            $display("FAIL pulse4_rise: rises=%0d at edge %0d, expected 1 at edge %0d", rise0_n, last_rise0, LAT);
        end
    endtask

    task automatic test_restart();
        settle(4'b0000, 14);
        clear_obs();
        for (int i = 0; i < 3; i++)  step(4'b0001, 1'b0, "restart");
        step(4'b0000, 1'b0, "restart");
        for (int i = 0; i < 4; i++)  step(4'b0001, 1'b0, "restart");
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, "restart");
        checks++;
        if (rise0_n != (FILT_ON ? 1 : 2) || last_rise0 != 4 + LAT) begin
            errors++;
            $display("FAIL restart: rises=%0d last at edge %0d, expected %0d last at edge %0d",
                     rise0_n, last_rise0, FILT_ON ? 1 : 2, 4 + LAT);
        end
    endtask

    task automatic test_simultaneous();
        settle(4'b0010, 14);
        clear_obs();
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0, "simul");
        checks++;
        if (chg_n != 1 || last_chg != LAT || chg_rise !== 4'b0001 || chg_fall !== 4'b0010) begin
            errors++;
            $display("FAIL simultaneous: chg cycles=%0d at edge %0d rise=%b fall=%b, expected 1 at edge %0d rise=0001 fall=0010",
                     chg_n, last_chg, chg_rise, chg_fall, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        settle(4'b0000, 14);
        clear_obs();
        v = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(v, 1'b0, "toggle");
            v = v ^ 4'b0001;
        end
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, "toggle");
        checks++;
        if (chg_n != (FILT_ON ? 0 : 10)) begin
            errors++;
            $display("FAIL toggle_changes: got %0d, expected %0d", chg_n, FILT_ON ? 0 : 10);
        end
    endtask

    task automatic test_mid_reset();
        int hit;
        settle(4'b0000, 14);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, "mid_reset_pre");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sync_out, rise_pulse, fall_pulse, chg_any} !== {RV, 4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: out=%b rise=%b fall=%b chg=%b, expected out=%b and no pulses",
                     sync_out, rise_pulse, fall_pulse, chg_any, RV);
        end
        model_reset();
        step(4'b0001, 1'b1, "mid_reset_hold");
        step(4'b0001, 1'b1, "mid_reset_hold");
        clear_obs();
        hit = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0001, 1'b0, "mid_reset_release");
            if (hit == 0 && sync_out === 4'b0001) hit = step_idx;
        end
        checks++;
        if (hit != LAT) begin
            errors++;
            $display("FAIL mid_reset_relatency: got edge %0d, expected %0d", hit, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_restart();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
